// File: rtl/utopia_rx_scheduler.sv
// Round-robin scheduler for a bank of Utopia-1 ATM receivers: arms each receiver,
// grants completed cells to the switch core one at a time, then releases and re-arms.
module utopia_rx_scheduler #(
  parameter int NumRx      = 4,
  parameter int RelTimeout = 64,
  localparam int PortW     = (NumRx > 1) ? $clog2(NumRx) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [NumRx-1:0]  port_en,
  input  logic [NumRx-1:0]  rx_valid,
  output logic [NumRx-1:0]  rx_ready,
  output logic              fwd_valid,
  output logic [PortW-1:0]  fwd_port,
  input  logic              fwd_ready,
  input  logic              err_clr,
  output logic [NumRx-1:0]  rel_err,
  output logic [15:0]       cell_count
);

  localparam int CntW = ($clog2(RelTimeout + 1) > 7) ? $clog2(RelTimeout + 1) : 7;

  typedef enum logic [1:0] {
    S_ARM,
    S_PEND,
    S_RELEASE
  } port_state_e;

  port_state_e            state_q [NumRx];
  port_state_e            state_d [NumRx];
  logic [CntW-1:0]        cnt_q   [NumRx];
  logic [CntW-1:0]        cnt_d   [NumRx];
  logic [NumRx-1:0]       rx_ready_q, rx_ready_d;
  logic [NumRx-1:0]       rel_err_q, rel_err_d;
  logic [NumRx-1:0]       err_set;
  logic [NumRx-1:0]       pend;
  logic [NumRx-1:0]       grant_oh;
  logic [NumRx-1:0]       cand;
  logic                   fwd_valid_q, fwd_valid_d;
  logic [PortW-1:0]       fwd_port_q, fwd_port_d;
  logic [PortW-1:0]       ptr_q, ptr_d;
  logic [15:0]            cell_count_q, cell_count_d;
  logic                   accept;
  logic                   found;
  logic [PortW-1:0]       winner;
  int unsigned            idx;

  assign accept = fwd_valid_q & fwd_ready;

  always_comb begin
    grant_oh = '0;
    for (int unsigned i = 0; i < NumRx; i++) begin
      grant_oh[i] = fwd_valid_q && (fwd_port_q == PortW'(i));
    end
  end

  // Per-port ARM / PEND / RELEASE sequencing
  always_comb begin
    rx_ready_d = rx_ready_q;
    err_set    = '0;
    pend       = '0;
    for (int unsigned i = 0; i < NumRx; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pend[i]    = (state_q[i] == S_PEND);
      case (state_q[i])
        S_ARM: begin
          rx_ready_d[i] = port_en[i];
          if (rx_ready_q[i] && rx_valid[i]) begin
            state_d[i]    = S_PEND;
            rx_ready_d[i] = 1'b1;
          end
        end
        S_PEND: begin
          rx_ready_d[i] = 1'b1;
          if (accept && grant_oh[i]) begin
            state_d[i]    = S_RELEASE;
            rx_ready_d[i] = 1'b0;
            cnt_d[i]      = '0;
          end
        end
        S_RELEASE: begin
          rx_ready_d[i] = 1'b0;
          if (!rx_valid[i]) begin
            state_d[i] = S_ARM;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] < CntW'(RelTimeout)) begin
            // Counter saturates at RelTimeout so the error is raised exactly once per stall
            cnt_d[i] = cnt_q[i] + CntW'(1);
            if (cnt_q[i] == CntW'(RelTimeout - 1)) begin
              err_set[i] = 1'b1;
            end
          end
        end
        default: begin
          state_d[i]    = S_ARM;
          rx_ready_d[i] = 1'b0;
          cnt_d[i]      = '0;
        end
      endcase
    end
  end

  // Round-robin search starting one past the last winner; the port being accepted is excluded
  always_comb begin
    cand   = pend & ~grant_oh;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= NumRx; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NumRx) begin
        idx = idx - NumRx;
      end
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = PortW'(idx);
      end
    end
  end

  always_comb begin
    fwd_valid_d  = fwd_valid_q;
    fwd_port_d   = fwd_port_q;
    ptr_d        = ptr_q;
    cell_count_d = cell_count_q;
    if (!fwd_valid_q || fwd_ready) begin
      if (found) begin
        fwd_valid_d = 1'b1;
        fwd_port_d  = winner;
        ptr_d       = winner;
      end else begin
        fwd_valid_d = 1'b0;
      end
    end
    if (accept) begin
      cell_count_d = cell_count_q + 16'd1;
    end
    rel_err_d = (rel_err_q & ~{NumRx{err_clr}}) | err_set;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NumRx; i++) begin
        state_q[i] <= S_ARM;
        cnt_q[i]   <= '0;
      end
      rx_ready_q   <= '0;
      rel_err_q    <= '0;
      fwd_valid_q  <= 1'b0;
      fwd_port_q   <= '0;
      ptr_q        <= PortW'(NumRx - 1);
      cell_count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumRx; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      rx_ready_q   <= rx_ready_d;
      rel_err_q    <= rel_err_d;
      fwd_valid_q  <= fwd_valid_d;
      fwd_port_q   <= fwd_port_d;
      ptr_q        <= ptr_d;
      cell_count_q <= cell_count_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign rel_err    = rel_err_q;
  assign fwd_valid  = fwd_valid_q;
  assign fwd_port   = fwd_port_q;
  assign cell_count = cell_count_q;

endmodule

// File: tb/tb_utopia_rx_scheduler.sv
// Directed bench for utopia_rx_scheduler: a 4-port instance for sequencing/arbitration
// checks and an 8-port instance driven at full rate for the cell counter wrap.
module tb_utopia_rx_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [3:0]  port_en, rx_valid, rx_ready, rel_err;
  logic        fwd_valid, fwd_ready, err_clr;
  logic [1:0]  fwd_port;
  logic [15:0] cell_count;

  logic [7:0]  port_en2, rx_valid2, rx_ready2, rel_err2;
  logic        fwd_valid2, fwd_ready2, err_clr2;
  logic [2:0]  fwd_port2;
  logic [15:0] cell_count2;

  int total = 0;
  int bad   = 0;
  int n_acc;
  int cyc;

  always #5 clk = ~clk;

  utopia_rx_scheduler #(.NumRx(4), .RelTimeout(8)) dut (
    .clk_in(clk), .reset_n(reset_n), .port_en(port_en), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fwd_valid(fwd_valid), .fwd_port(fwd_port),
    .fwd_ready(fwd_ready), .err_clr(err_clr), .rel_err(rel_err), .cell_count(cell_count)
  );

  utopia_rx_scheduler #(.NumRx(8), .RelTimeout(64)) dut_wrap (
    .clk_in(clk), .reset_n(reset_n), .port_en(port_en2), .rx_valid(rx_valid2),
    .rx_ready(rx_ready2), .fwd_valid(fwd_valid2), .fwd_port(fwd_port2),
    .fwd_ready(fwd_ready2), .err_clr(err_clr2), .rel_err(rel_err2), .cell_count(cell_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    port_en = '0; rx_valid = '0; fwd_ready = 1'b0; err_clr = 1'b0;
    port_en2 = '0; rx_valid2 = '0; fwd_ready2 = 1'b0; err_clr2 = 1'b0;

    // Reset state
    #12;
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_fwd_valid", 32'(fwd_valid), 0);
    chk("rst_fwd_port", 32'(fwd_port), 0);
    chk("rst_rel_err", 32'(rel_err), 0);
    chk("rst_cell_count", 32'(cell_count), 0);

    // Single port 2
    port_en = 4'b0100;
    do_reset();
    tick();
    chk("t1_armed", 32'(rx_ready), 32'h4);
    rx_valid = 4'b0100;
    fwd_ready = 1'b1;
    tick();
    chk("t1_no_early_grant", 32'(fwd_valid), 0);
    tick();
    chk("t1_grant", 32'({fwd_valid, fwd_port}), 32'b110);
    tick();
    chk("t1_released", 32'(rx_ready), 0);
    chk("t1_count", 32'(cell_count), 1);
    chk("t1_idle", 32'(fwd_valid), 0);
    rx_valid = 4'b0000;
    tick();
    chk("t1_rearm_wait", 32'(rx_ready), 0);
    tick();
    chk("t1_rearmed", 32'(rx_ready), 32'h4);
    chk("t1_count_hold", 32'(cell_count), 1);

    // Round robin across all four ports
    port_en = 4'hF;
    do_reset();
    tick();
    chk("t2_armed", 32'(rx_ready), 32'hF);
    rx_valid = 4'hF;
    tick();
    tick();
    chk("t2_grant0", 32'({fwd_valid, fwd_port}), 32'b100);
    rx_valid = 4'b1110;
    tick();
    chk("t2_grant1", 32'({fwd_valid, fwd_port}), 32'b101);
    rx_valid = 4'b1100;
    tick();
    chk("t2_grant2", 32'({fwd_valid, fwd_port}), 32'b110);
    rx_valid = 4'b1000;
    tick();
    chk("t2_grant3", 32'({fwd_valid, fwd_port}), 32'b111);
    rx_valid = 4'b0000;
    tick();
    chk("t2_drained", 32'(fwd_valid), 0);
    chk("t2_count", 32'(cell_count), 4);
    tick();
    tick();
    chk("t2_all_rearmed", 32'(rx_ready), 32'hF);
    rx_valid = 4'b1001;
    tick();
    tick();
    chk("t2_ptr_wrap_0", 32'({fwd_valid, fwd_port}), 32'b100);
    tick();
    chk("t2_then_3", 32'({fwd_valid, fwd_port}), 32'b111);
    rx_valid = 4'b0000;
    tick();
    chk("t2_count6", 32'(cell_count), 6);
    tick();
    tick();

    // Backpressure: port 1 granted, port 3 pending
    fwd_ready = 1'b0;
    rx_valid = 4'b1010;
    tick();
    tick();
    chk("t3_grant1", 32'({fwd_valid, fwd_port}), 32'b101);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_hold", 32'({fwd_valid, fwd_port}), 32'b101);
    end
    fwd_ready = 1'b1;
    tick();
    fwd_ready = 1'b0;
    chk("t3_next3", 32'({fwd_valid, fwd_port}), 32'b111);
    chk("t3_count7", 32'(cell_count), 7);
    rx_valid = 4'b1000;
    fwd_ready = 1'b1;
    tick();
    chk("t3_count8", 32'(cell_count), 8);
    rx_valid = 4'b0000;
    tick();
    tick();
    tick();

    // Release timeout on port 0 (RelTimeout = 8)
    rx_valid = 4'b0001;
    tick();
    tick();
    chk("t4_grant0", 32'({fwd_valid, fwd_port}), 32'b100);
    tick();
    chk("t4_count9", 32'(cell_count), 9);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("t4_no_err_yet", 32'({rel_err, rx_ready[0], fwd_valid}), 0);
    end
    tick();
    chk("t4_err_set", 32'(rel_err), 32'h1);
    chk("t4_ready_low", 32'(rx_ready[0]), 0);
    tick();
    tick();
    tick();
    chk("t4_no_regrant", 32'({fwd_valid, rx_ready[0]}), 0);
    chk("t4_err_sticky", 32'(rel_err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr", 32'(rel_err), 0);
    rx_valid = 4'b0000;
    tick();
    tick();
    chk("t4_rearm", 32'(rx_ready), 32'hF);

    // Disable in ARM, then reset mid-grant
    port_en = 4'b1101;
    tick();
    chk("t5_disable", 32'(rx_ready), 32'hD);
    port_en = 4'hF;
    rx_valid = 4'b0100;
    fwd_ready = 1'b0;
    tick();
    tick();
    chk("t5_granted", 32'({fwd_valid, fwd_port}), 32'b110);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_ready", 32'(rx_ready), 0);
    chk("t5_async_valid", 32'(fwd_valid), 0);
    chk("t5_async_port", 32'(fwd_port), 0);
    chk("t5_async_count", 32'(cell_count), 0);
    chk("t5_async_err", 32'(rel_err), 0);
    rx_valid = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;

    // Counter wrap on the 8-port instance, receivers answer ready with valid
    port_en2 = 8'hFF;
    fwd_ready2 = 1'b1;
    n_acc = 0;
    cyc = 0;
    while (n_acc < 65535 && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      rx_valid2 = rx_ready2;
      if (fwd_valid2) n_acc++;
    end
    chk("t6_accept_budget", 32'(n_acc), 65535);
    @(posedge clk);
    #1;
    fwd_ready2 = 1'b0;
    chk("t6_count_ffff", 32'(cell_count2), 32'hFFFF);
    cyc = 0;
    while (!fwd_valid2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      rx_valid2 = rx_ready2;
    end
    chk("t6_grant_ready", 32'(fwd_valid2), 1);
    fwd_ready2 = 1'b1;
    @(posedge clk);
    #1;
    fwd_ready2 = 1'b0;
    chk("t6_count_wrap", 32'(cell_count2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/utopia_rx_scheduler.md
Name: utopia_rx_scheduler

Overview:
- Sequences a bank of NumRx Utopia-1 ATM receivers.
- Drives each receiver's ready input, collects completed-cell valid flags, and arbitrates round-robin among them.
- Presents one granted port index per cell to the switch core over a valid/ready forward handshake. The core muxes the granted receiver's ATMcell.
- Releases each receiver after its cell is accepted, then re-arms it.

Parameters:
- NumRx, 4, number of receivers scheduled (2..16).
- RelTimeout, 64, cycles a port may wait in RELEASE for rx_valid to fall before its error flag sets (>=2).

Ports:
- clk_in  input  1  receiver clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- port_en  input  NumRx  per-port enable; a disabled port is not re-armed.
- rx_valid  input  NumRx  receiver i holds a complete cell.
- rx_ready  output  NumRx  enable to receiver i; 1 = may capture a cell, falling edge = cell consumed.
- fwd_valid  output  1  fwd_port holds a granted port with a cell to forward.
- fwd_port  output  $clog2(NumRx)  granted port index.
- fwd_ready  input  1  core accepts the grant this cycle.
- err_clr  input  1  one-cycle pulse; clears all rel_err bits.
- rel_err  output  NumRx  sticky: port exceeded RelTimeout in RELEASE.
- cell_count  output  16  total cells accepted; wraps 0xFFFF->0.

Behaviour:
- Reset (async, reset_n low):
  - rx_ready=0, fwd_valid=0, fwd_port=0, rel_err=0, cell_count=0.
  - All ports in ARM, RR pointer=NumRx-1 so port 0 has first priority.
- Per-port FSM, states ARM, PEND, RELEASE:
  - ARM: rx_ready[i] <= port_en[i] each cycle. If rx_ready[i]&&rx_valid[i] is sampled, go to PEND. rx_valid while rx_ready=0 is ignored.
  - PEND: rx_ready[i] held 1, since the receiver ignores ready while finishing. Leave PEND only when granted and accepted, then go to RELEASE with rx_ready[i] <= 0 at the same edge.
  - RELEASE: rx_ready[i]=0. A 7-bit-min counter increments each cycle.
    - When rx_valid[i]==0 is sampled: go to ARM and clear the counter. rx_ready rises the next cycle if port_en[i].
    - When the counter reaches RelTimeout: rel_err[i] <= 1 and stay in RELEASE. Never re-arm while valid is high, so no duplicate cell.
- port_en deassert:
  - In ARM: rx_ready drops at the next edge. A cell already underway still completes and is served.
  - In PEND or RELEASE: no effect until back in ARM.
- Arbiter:
  - Candidates: ports in PEND and not currently granted.
  - Selection order: first candidate at index pointer+1, pointer+2, ... modulo NumRx.
  - Grant is registered: when fwd_valid==0, or fwd_valid&&fwd_ready, and a candidate exists, then fwd_valid <= 1, fwd_port <= winner, pointer <= winner.
  - If no candidate exists in that case, fwd_valid <= 0.
  - fwd_port stays stable while fwd_valid&&!fwd_ready.
- Back-to-back: the accept edge may load the next grant, so fwd_valid stays 1 with a new fwd_port. The accepted port is excluded from that selection.
- Latency: rx_valid[i] first sampled at edge E gives PEND after E. The earliest fwd_valid=1, fwd_port=i is after edge E+1.
- cell_count increments by 1 on every fwd_valid&&fwd_ready edge.
- err_clr vs new error in the same cycle: set wins.
- Reset asserted mid-cell or mid-grant: all state returns to reset values immediately. rx_ready=0 forces the receivers back through their own reset path.

Test Plan:
- Single port: NumRx=4, only port 2 enabled. Raise rx_valid[2] at edge 10, hold fwd_ready=1.
  - Required: fwd_valid=1, fwd_port=2 after edge 11.
  - Required: rx_ready[2]=0 after edge 12.
  - Drop rx_valid at edge 13; required: rx_ready[2]=1 after edge 14 and cell_count=1.
- Round robin: all four ports valid in the same cycle, fwd_ready=1.
  - Required: grants in order 0,1,2,3 on consecutive cycles, no fwd_valid gap.
  - Re-raise ports 0 and 3; required: 0 is served next because pointer=3.
- Backpressure: hold fwd_ready=0 for 20 cycles with port 1 granted and port 3 pending.
  - Required: fwd_port stays 1 and fwd_valid stays 1.
  - Then pulse fwd_ready; required: the next grant is 3.
- Release timeout: RelTimeout=8, keep rx_valid[0] high after acceptance.
  - Required: rel_err[0]=1 after 8 cycles in RELEASE, rx_ready[0] stays 0, no re-grant of port 0.
  - Pulse err_clr; required: rel_err=0.
- Disable / reset: clear port_en[1] in ARM; required: rx_ready[1]=0 next edge.
  - Assert reset_n=0 mid-grant; required: all outputs 0 asynchronously.
- Counter wrap: preload via 65535 accepts; the next accept must give cell_count=0.
